// File: rtl/myiplcd_axil_pkg.sv
// Shared types and helpers for the LCD IP AXI4-Lite register slave.
// Holds the FSM state encodings, register indices and the byte-merge function.
package myiplcd_axil_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_CMD  = 2'd2;
    localparam logic [1:0] REG_AUX  = 2'd3;

    // Byte b of the result comes from new_val where strb[b] is set, else from old_val.
    function automatic logic [31:0] wstrb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/myiplcd_reg_bank.sv
// Four 32-bit LCD control registers with a byte-merging write port and an
// asynchronous read mux; all four values are also exported directly.
module myiplcd_reg_bank
    import myiplcd_axil_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  logic [1:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] reg0_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] reg3_o
);

    logic [31:0] reg_q [4];
    logic [31:0] merged_d;

    assign merged_d = wstrb_merge(reg_q[wr_idx_i], wr_data_i, wr_strb_i);

    // NOTE: non-blocking (<=) for every flop so all registers update together
    // at the edge and readers in the same cycle see the pre-write value.
    always_ff @(posedge clk_i) begin
        // NOTE: this storage is reset explicitly because software expects the
        // register bank to read back zero after reset, unlike a plain RAM.
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            reg_q[wr_idx_i] <= merged_d;
        end
    end

    assign rd_data_o = reg_q[rd_idx_i];
    assign reg0_o    = reg_q[REG_CTRL];
    assign reg1_o    = reg_q[REG_DATA];
    assign reg2_o    = reg_q[REG_CMD];
    assign reg3_o    = reg_q[REG_AUX];

endmodule

// File: rtl/myiplcd_axil_slave.sv
// AXI4-Lite slave for the LCD IP: independent write and read FSMs in front of
// a four-register bank, plus a one-cycle commit strobe for downstream logic.
module myiplcd_axil_slave
    import myiplcd_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     slv_reg0,
    output logic [31:0]                     slv_reg1,
    output logic [31:0]                     slv_reg2,
    output logic [31:0]                     slv_reg3,
    output logic                            reg_wr_strobe,
    output logic [1:0]                      reg_wr_index
);

    wr_state_e   wr_state_q, wr_state_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic        aw_rdy, w_rdy, commit;

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        ar_rdy;
    logic [31:0] bank_rd_data;

    // Write FSM: AW and W may arrive together or in either order.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // through the case leaves one unassigned and infers a latch.
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        commit     = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (s00_axi_awvalid) begin
                    waddr_d = s00_axi_awaddr[3:2];
                end
                if (s00_axi_wvalid) begin
                    wdata_d = s00_axi_wdata;
                    wstrb_d = s00_axi_wstrb;
                end
                if (s00_axi_awvalid && s00_axi_wvalid) begin
                    wr_state_d = W_COMMIT;
                end else if (s00_axi_awvalid) begin
                    wr_state_d = W_HAVE_A;
                end else if (s00_axi_wvalid) begin
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_rdy = 1'b1;
                if (s00_axi_wvalid) begin
                    wdata_d    = s00_axi_wdata;
                    wstrb_d    = s00_axi_wstrb;
                    wr_state_d = W_COMMIT;
                end
            end
            W_HAVE_D: begin
                aw_rdy = 1'b1;
                if (s00_axi_awvalid) begin
                    waddr_d    = s00_axi_awaddr[3:2];
                    wr_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                commit     = 1'b1;
                bvalid_d   = 1'b1;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM: data is captured from the bank on the AR handshake edge.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        ar_rdy     = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (s00_axi_arvalid) begin
                    rdata_d    = bank_rd_data;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    myiplcd_reg_bank u_reg_bank (
        .clk_i     (s00_axi_aclk),
        .rst_i     (s00_axi_areset),
        .wr_en_i   (commit),
        .wr_idx_i  (waddr_q),
        .wr_data_i (wdata_q),
        .wr_strb_i (wstrb_q),
        .rd_idx_i  (s00_axi_araddr[3:2]),
        .rd_data_o (bank_rd_data),
        .reg0_o    (slv_reg0),
        .reg1_o    (slv_reg1),
        .reg2_o    (slv_reg2),
        .reg3_o    (slv_reg3)
    );

    // Readies and the strobe are masked by reset so every output is 0 while reset is held.
    assign s00_axi_awready = aw_rdy & ~s00_axi_areset;
    assign s00_axi_wready  = w_rdy & ~s00_axi_areset;
    assign s00_axi_arready = ar_rdy & ~s00_axi_areset;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign reg_wr_strobe   = commit & ~s00_axi_areset;
    assign reg_wr_index    = reg_wr_strobe ? waddr_q : 2'd0;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_myiplcd_axil_slave.sv
// Scoreboard bench for myiplcd_axil_slave: stimulus queues expected B/R/commit
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_myiplcd_axil_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic        reg_wr_strobe;
    logic [1:0]  reg_wr_index;

    always #5 clk = ~clk;

    myiplcd_axil_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .slv_reg0        (slv_reg0),
        .slv_reg1        (slv_reg1),
        .slv_reg2        (slv_reg2),
        .slv_reg3        (slv_reg3),
        .reg_wr_strobe   (reg_wr_strobe),
        .reg_wr_index    (reg_wr_index)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    int last_b_cyc  = 0;
    int last_aw_cyc = 0;

    logic [1:0]  exp_b  [$];
    logic [31:0] exp_r  [$];
    logic [1:0]  exp_wr [$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Monitor: a valid&ready seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!areset) begin
            if (bvalid && bready) begin
                last_b_cyc = cyc_cnt;
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_b: got a B handshake, want none");
                end else begin
                    e = {30'b0, exp_b.pop_front()};
                    check("bresp", {30'b0, bresp}, e);
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_r: got an R handshake, want none");
                end else begin
                    e = exp_r.pop_front();
                    check("rdata", rdata, e);
                    check("rresp", {30'b0, rresp}, 32'd0);
                end
            end
            if (reg_wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_commit: got strobe idx %0d, want none", reg_wr_index);
                end else begin
                    e = {30'b0, exp_wr.pop_front()};
                    check("wr_index", {30'b0, reg_wr_index}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        exp_b.push_back(2'b00);
        exp_wr.push_back(addr[3:2]);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (aw_hs) last_aw_cyc = cyc_cnt;
            @(posedge clk);
            #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_ar(input logic [3:0] addr);
        bit hs = 0;
        int cyc = 0;
        araddr = addr;
        while (!hs && cyc < 100) begin
            arvalid = 1'b1;
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!hs) check("ar_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        exp_r.push_back(exp);
        axi_ar(addr);
    endtask

    // Called right after the final AW/W handshake edge.
    task automatic check_b_latency(input string tag);
        @(negedge clk);
        check({tag, "_bvalid_c1"}, {31'b0, bvalid}, 32'd0);
        check({tag, "_strobe_c1"}, {31'b0, reg_wr_strobe}, 32'd1);
        tick();
        @(negedge clk);
        check({tag, "_bvalid_c2"}, {31'b0, bvalid}, 32'd1);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, {31'b0, awready}, 32'd0);
        check({tag, "_wready"},  {31'b0, wready},  32'd0);
        check({tag, "_arready"}, {31'b0, arready}, 32'd0);
        check({tag, "_bvalid"},  {31'b0, bvalid},  32'd0);
        check({tag, "_bresp"},   {30'b0, bresp},   32'd0);
        check({tag, "_rvalid"},  {31'b0, rvalid},  32'd0);
        check({tag, "_rresp"},   {30'b0, rresp},   32'd0);
        check({tag, "_rdata"},   rdata,            32'd0);
        check({tag, "_slv_reg0"}, slv_reg0, 32'd0);
        check({tag, "_slv_reg1"}, slv_reg1, 32'd0);
        check({tag, "_slv_reg2"}, slv_reg2, 32'd0);
        check({tag, "_slv_reg3"}, slv_reg3, 32'd0);
        check({tag, "_strobe"},  {31'b0, reg_wr_strobe}, 32'd0);
        check({tag, "_index"},   {30'b0, reg_wr_index},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        tick();
        areset = 1'b0;
        @(negedge clk);
        check("idle_awready", {31'b0, awready}, 32'd1);
        check("idle_arready", {31'b0, arready}, 32'd1);
        tick();

        // Four full-word writes, then read them back
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        end
        repeat (3) tick();
        check("t1_slv_reg0", slv_reg0, 32'h1);
        check("t1_slv_reg1", slv_reg1, 32'h2);
        check("t1_slv_reg2", slv_reg2, 32'h3);
        check("t1_slv_reg3", slv_reg3, 32'h4);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 32'(i + 1));
        end
        repeat (3) tick();

        // AW three cycles ahead of W, then W three cycles ahead of AW
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 0, 3);
        check_b_latency("aw_first");
        check("aw_first_slv_reg2", slv_reg2, 32'hDEADBEEF);
        axi_write(4'h8, 32'h0, 4'hF, 0, 0);
        repeat (3) tick();
        check("cleared_slv_reg2", slv_reg2, 32'h0);
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
        check_b_latency("w_first");
        check("w_first_slv_reg2", slv_reg2, 32'hDEADBEEF);
        repeat (2) tick();

        // Byte-strobe merge
        axi_write(4'h4, 32'h11223344, 4'hF, 0, 0);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0);
        repeat (3) tick();
        check("strb_slv_reg1", slv_reg1, 32'h11BB33DD);
        axi_read(4'h4, 32'h11BB33DD);
        repeat (3) tick();

        // B backpressure: no new AW until the B handshake completes
        bready = 1'b0;
        axi_write(4'h0, 32'h5, 4'hF, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_bvalid",  {31'b0, bvalid},  32'd1);
            check("bp_awready", {31'b0, awready}, 32'd0);
            check("bp_wready",  {31'b0, wready},  32'd0);
            tick();
        end
        fork
            axi_write(4'hC, 32'h66, 4'hF, 0, 0);
            begin
                repeat (3) tick();
                bready = 1'b1;
            end
        join
        check("aw_after_b", {31'b0, (last_aw_cyc > last_b_cyc)}, 32'd1);
        repeat (3) tick();
        check("bp_slv_reg0", slv_reg0, 32'h5);
        check("bp_slv_reg3", slv_reg3, 32'h66);

        // AR handshake on the same edge as a commit to the same register
        axi_write(4'h4, 32'h2, 4'hF, 0, 0);
        repeat (3) tick();
        rready = 1'b0;
        exp_r.push_back(32'h2);
        fork
            axi_write(4'h4, 32'h55, 4'hF, 0, 0);
            begin
                tick();
                axi_ar(4'h4);
            end
        join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid", {31'b0, rvalid}, 32'd1);
            check("hold_rdata",  rdata, 32'h2);
            tick();
        end
        rready = 1'b1;
        repeat (2) tick();
        axi_read(4'h4, 32'h55);
        repeat (3) tick();

        // Reset while in W_HAVE_A and R_DATA
        rready  = 1'b0;
        awaddr  = 4'h4;
        awvalid = 1'b1;
        araddr  = 4'h4;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        areset = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("rst_mid");
        tick();
        areset = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", {31'b0, bvalid}, 32'd0);
            check("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 32'h0);
        end
        repeat (5) tick();

        check("b_queue_empty",  32'(exp_b.size()),  32'd0);
        check("r_queue_empty",  32'(exp_r.size()),  32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
